// File: rtl/axi_lut_pkg.sv
// Shared constants for the table-lookup multiplier: FSM state codes, AXI response
// codes and the table-index to byte-address mapping.
package axi_lut_pkg;

    localparam logic [2:0] ST_FILL_AW = 3'd0;
    localparam logic [2:0] ST_FILL_B  = 3'd1;
    localparam logic [2:0] ST_IDLE    = 3'd2;
    localparam logic [2:0] ST_RD_AR   = 3'd3;
    localparam logic [2:0] ST_RD_R    = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One 32-bit word per entry, so the index is scaled by four bytes.
    function automatic logic [31:0] idx_to_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/axi_lut_multiplier_if.sv
// AXI4-lite bus between the lookup multiplier (master) and the table RAM (slave).
// Every channel uses valid/ready: a transfer happens in the cycle both are high, and
// once valid is raised it and its payload stay put until that cycle.
interface axi_lut_multiplier_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lut_fill.sv
// Fill engine: walks idx over the whole table, writing a*b to each entry through the
// AW/W/B channels. The top FSM tells it which fill phase is current.
module axi_lut_fill
    import axi_lut_pkg::*;
#(
    parameter int          OPW       = 3,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_aw,
    input  logic        in_b,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic [31:0] awaddr,
    output logic        awvalid,
    output logic [31:0] wdata,
    output logic        wvalid,
    output logic        bready,
    output logic        aw_complete,
    output logic        b_complete,
    output logic        last,
    output logic        b_err
);
    localparam int IW = 2 * OPW;

    logic [IW-1:0] idx_q, idx_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic [31:0]   awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          aw_hs, w_hs, next_aw, next_b;
    logic [IW-1:0] op_a, op_b;

    always_comb begin
        aw_hs       = awvalid_q & awready;
        w_hs        = wvalid_q & wready;
        aw_complete = in_aw & (aw_done_q | aw_hs) & (w_done_q | w_hs);
        b_complete  = in_b & bready_q & bvalid;
        last        = &idx_q;
        b_err       = b_complete & (bresp != RESP_OKAY);
        next_aw     = (in_aw & ~aw_complete) | (b_complete & ~last);
        next_b      = aw_complete | (in_b & ~b_complete);
        // The increment past the last entry wraps idx back to zero.
        idx_d       = b_complete ? idx_q + 1'b1 : idx_q;
        aw_done_d   = in_aw & ~aw_complete & (aw_done_q | aw_hs);
        w_done_d    = in_aw & ~aw_complete & (w_done_q | w_hs);
        awvalid_d   = next_aw & ~aw_done_d;
        wvalid_d    = next_aw & ~w_done_d;
        bready_d    = next_b;
        op_a        = {{OPW{1'b0}}, idx_d[IW-1:OPW]};
        op_b        = {{OPW{1'b0}}, idx_d[OPW-1:0]};
        // Address and data track idx_d so they are already valid when awvalid rises.
        awaddr_d    = idx_to_addr(ADDR_BASE, 16'(idx_d));
        wdata_d     = 32'(op_a * op_b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
        end else begin
            idx_q     <= idx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;

endmodule

// File: rtl/axi_lut_multiplier.sv
// Table-lookup multiplier acting as AXI4-lite master onto a times-table RAM.
// Define AXI_LUT_FILL_EN to have it write the table itself after reset.
module axi_lut_multiplier
    import axi_lut_pkg::*;
#(
    parameter int          OPW       = 3,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPW-1:0]       a,
    input  logic [OPW-1:0]       b,
    input  logic                 read,
    output logic                 busy,
    output logic [2*OPW-1:0]     result,
    output logic                 result_valid,
    output logic                 resp_err,
    output logic [2:0]           dbg_state,
    axi_lut_multiplier_if.master m_axi
);
    logic [2:0]       state_q, state_d;
    logic [31:0]      araddr_q, araddr_d;
    logic             arvalid_q, arvalid_d;
    logic             rready_q, rready_d;
    logic [2*OPW-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             resp_err_q, resp_err_d;
    logic             fill_aw_complete, fill_b_complete, fill_last, fill_b_err;
    logic             unused_rdata;

`ifdef AXI_LUT_FILL_EN
    localparam logic [2:0] RESET_STATE = ST_FILL_AW;

    axi_lut_fill #(.OPW(OPW), .ADDR_BASE(ADDR_BASE)) u_fill (
        .clk         (clk),
        .rst         (rst),
        .in_aw       (state_q == ST_FILL_AW),
        .in_b        (state_q == ST_FILL_B),
        .awready     (m_axi.awready),
        .wready      (m_axi.wready),
        .bvalid      (m_axi.bvalid),
        .bresp       (m_axi.bresp),
        .awaddr      (m_axi.awaddr),
        .awvalid     (m_axi.awvalid),
        .wdata       (m_axi.wdata),
        .wvalid      (m_axi.wvalid),
        .bready      (m_axi.bready),
        .aw_complete (fill_aw_complete),
        .b_complete  (fill_b_complete),
        .last        (fill_last),
        .b_err       (fill_b_err)
    );
`else
    localparam logic [2:0] RESET_STATE = ST_IDLE;
    logic unused_fill;

    assign m_axi.awaddr     = '0;
    assign m_axi.awvalid    = 1'b0;
    assign m_axi.wdata      = '0;
    assign m_axi.wvalid     = 1'b0;
    assign m_axi.bready     = 1'b0;
    assign fill_aw_complete = 1'b0;
    assign fill_b_complete  = 1'b0;
    assign fill_last        = 1'b0;
    assign fill_b_err       = 1'b0;
    assign unused_fill      = ^{m_axi.awready, m_axi.wready, m_axi.bvalid, m_axi.bresp};
`endif

    always_comb begin
        state_d        = state_q;
        araddr_d       = araddr_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        resp_err_d     = resp_err_q;
        case (state_q)
            ST_FILL_AW: if (fill_aw_complete) state_d = ST_FILL_B;
            ST_FILL_B:  if (fill_b_complete) state_d = fill_last ? ST_IDLE : ST_FILL_AW;
            ST_IDLE: begin
                // Operands are captured only here; strobes in other states are dropped.
                if (read) begin
                    state_d   = ST_RD_AR;
                    araddr_d  = idx_to_addr(ADDR_BASE, 16'({a, b}));
                    arvalid_d = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (m_axi.arready) begin
                    state_d   = ST_RD_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_R: begin
                if (m_axi.rvalid) begin
                    state_d        = ST_IDLE;
                    rready_d       = 1'b0;
                    result_d       = m_axi.rdata[2*OPW-1:0];
                    result_valid_d = 1'b1;
                    if (m_axi.rresp != RESP_OKAY) resp_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fill_b_err) resp_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RESET_STATE;
            araddr_q       <= '0;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            resp_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            araddr_q       <= araddr_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            resp_err_q     <= resp_err_d;
        end
    end

    assign unused_rdata  = ^m_axi.rdata[31:2*OPW];
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign busy          = (state_q != ST_IDLE);
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign resp_err      = resp_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi_lut_multiplier.sv
// Directed bench for axi_lut_multiplier with a behavioural AXI4-lite RAM slave.
// Covers the fill engine too when compiled with AXI_LUT_FILL_EN.
module tb_axi_lut_multiplier;
    import axi_lut_pkg::*;

    localparam int          OPW  = 3;
    localparam int          N    = 64;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef AXI_LUT_FILL_EN
    localparam logic       EXP_BUSY_RST  = 1'b1;
    localparam logic [2:0] EXP_STATE_RST = ST_FILL_AW;
`else
    localparam logic       EXP_BUSY_RST  = 1'b0;
    localparam logic [2:0] EXP_STATE_RST = ST_IDLE;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] a = '0;
    logic [2:0] b = '0;
    logic       read = 1'b0;
    logic       busy;
    logic [5:0] result;
    logic       result_valid;
    logic       resp_err;
    logic [2:0] dbg_state;

    axi_lut_multiplier_if m_axi ();

    axi_lut_multiplier #(.OPW(OPW), .ADDR_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .read         (read),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .resp_err     (resp_err),
        .dbg_state    (dbg_state),
        .m_axi        (m_axi)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int ridx(input logic [31:0] ad);
        logic [31:0] t;
        t = (ad - BASE) >> 2;
        return int'(t[5:0]);
    endfunction

    // behavioural RAM slave
    logic [31:0] mem [N];
    int          hits [N];
    int          ar_delay = 0;
    int          aw_delay = 0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [1:0]  bresp_cfg = 2'b00;
    int          ar_cnt, aw_cnt, ar_hs_count, wr_count;
    logic        aw_got, w_got, first_seen;
    logic [31:0] aw_addr_q, w_data_q, first_wr_addr;
    logic        sl_aw_hs, sl_w_hs, have_aw, have_w;
    logic [31:0] cur_addr, cur_data;

    always_comb begin
        sl_aw_hs = m_axi.awvalid & m_axi.awready;
        sl_w_hs  = m_axi.wvalid & m_axi.wready;
        have_aw  = aw_got | sl_aw_hs;
        have_w   = w_got | sl_w_hs;
        cur_addr = sl_aw_hs ? m_axi.awaddr : aw_addr_q;
        cur_data = sl_w_hs ? m_axi.wdata : w_data_q;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axi.arready <= (ar_delay == 0);
            m_axi.rvalid  <= 1'b0;
            m_axi.rdata   <= '0;
            m_axi.rresp   <= 2'b00;
            m_axi.awready <= (aw_delay == 0);
            m_axi.wready  <= 1'b1;
            m_axi.bvalid  <= 1'b0;
            m_axi.bresp   <= 2'b00;
            ar_cnt        <= 0;
            aw_cnt        <= 0;
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            wr_count      <= 0;
            first_seen    <= 1'b0;
            first_wr_addr <= '0;
            for (int i = 0; i < N; i++) hits[i] <= 0;
`ifndef AXI_LUT_FILL_EN
            for (int i = 0; i < N; i++) mem[i] <= 32'((i >> 3) * (i & 7));
`endif
        end else begin
            if (m_axi.rvalid && m_axi.rready) m_axi.rvalid <= 1'b0;
            if (m_axi.arvalid && m_axi.arready) begin
                m_axi.rvalid  <= 1'b1;
                m_axi.rdata   <= {16'hA5A5, mem[ridx(m_axi.araddr)][15:0]};
                m_axi.rresp   <= rresp_cfg;
                m_axi.arready <= (ar_delay == 0);
                ar_cnt        <= 0;
                ar_hs_count   <= ar_hs_count + 1;
            end else if (m_axi.arvalid) begin
                if (ar_cnt + 1 >= ar_delay) m_axi.arready <= 1'b1;
                ar_cnt <= ar_cnt + 1;
            end else begin
                m_axi.arready <= (ar_delay == 0);
                ar_cnt        <= 0;
            end

            if (m_axi.bvalid && m_axi.bready) m_axi.bvalid <= 1'b0;
            if (have_aw && have_w && !m_axi.bvalid) begin
                mem[ridx(cur_addr)]  <= cur_data;
                hits[ridx(cur_addr)] <= hits[ridx(cur_addr)] + 1;
                wr_count             <= wr_count + 1;
                if (!first_seen) begin
                    first_seen    <= 1'b1;
                    first_wr_addr <= cur_addr;
                end
                m_axi.bvalid  <= 1'b1;
                m_axi.bresp   <= bresp_cfg;
                aw_got        <= 1'b0;
                w_got         <= 1'b0;
                m_axi.awready <= (aw_delay == 0);
                aw_cnt        <= 0;
            end else begin
                aw_got <= have_aw;
                w_got  <= have_w;
                if (sl_aw_hs) aw_addr_q <= m_axi.awaddr;
                if (sl_w_hs) w_data_q <= m_axi.wdata;
                if (m_axi.awvalid && !m_axi.awready) begin
                    if (aw_cnt + 1 >= aw_delay) m_axi.awready <= 1'b1;
                    aw_cnt <= aw_cnt + 1;
                end else if (sl_aw_hs || !m_axi.awvalid) begin
                    m_axi.awready <= (aw_delay == 0);
                    aw_cnt        <= 0;
                end
            end
        end
    end

    initial ar_hs_count = 0;

    // valid/payload hold monitor while a handshake is pending
    logic        ar_pend, aw_pend;
    logic [31:0] ar_addr_prev, aw_addr_prev, w_data_prev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
        end else begin
            ar_pend      <= m_axi.arvalid && !m_axi.arready;
            aw_pend      <= m_axi.awvalid && !m_axi.awready;
            ar_addr_prev <= m_axi.araddr;
            aw_addr_prev <= m_axi.awaddr;
            w_data_prev  <= m_axi.wdata;
        end
    end

    always @(negedge clk) begin
        if (rst && ar_pend) begin
            check("arvalid_held", 32'(m_axi.arvalid), 32'd1);
            check("araddr_stable", m_axi.araddr, ar_addr_prev);
        end
        if (rst && aw_pend) begin
            check("awvalid_held", 32'(m_axi.awvalid), 32'd1);
            check("awaddr_stable", m_axi.awaddr, aw_addr_prev);
            check("wdata_stable", m_axi.wdata, w_data_prev);
        end
    end

    // driver tasks
    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(EXP_BUSY_RST));
        check({tag, "_state"}, 32'(dbg_state), 32'(EXP_STATE_RST));
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_ar"}, {m_axi.araddr[29:0], m_axi.arvalid, m_axi.rready}, 32'd0);
        check({tag, "_aw"}, {m_axi.awaddr[29:0], m_axi.awvalid, m_axi.wvalid}, 32'd0);
        check({tag, "_wdata_bready"}, {m_axi.wdata[30:0], m_axi.bready}, 32'd0);
    endtask

    task automatic wait_not_busy(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic do_lookup(input logic [2:0] ta, input logic [2:0] tb, input int dly,
                             input logic [1:0] rr, output logic [5:0] res, output int lat,
                             output int pulses, output logic [31:0] addr_seen);
        ar_delay  = dly;
        rresp_cfg = rr;
        @(negedge clk);
        a    = ta;
        b    = tb;
        read = 1'b1;
        @(negedge clk);
        read      = 1'b0;
        a         = 3'($urandom_range(0, 7));
        b         = 3'($urandom_range(0, 7));
        addr_seen = m_axi.araddr;
        lat       = 1;
        while (!result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res    = result;
        pulses = int'(result_valid);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses += int'(result_valid);
        end
    endtask

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        int         ar_delay;
        logic [1:0] rresp;
        logic [5:0] exp_result;
        logic       exp_err;
    } vec_t;

    vec_t        vecs [11];
    logic [5:0]  res;
    int          lat, pulses, n, hs_before, dup;
    logic [31:0] addr_seen;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0]  = '{3'd7, 3'd6, 0, 2'b00, 6'd42, 1'b0};
        vecs[1]  = '{3'd0, 3'd0, 0, 2'b00, 6'd0,  1'b0};
        vecs[2]  = '{3'd7, 3'd7, 0, 2'b00, 6'd49, 1'b0};
        vecs[3]  = '{3'd2, 3'd3, 3, 2'b00, 6'd6,  1'b0};
        vecs[4]  = '{3'd5, 3'd5, 1, 2'b00, 6'd25, 1'b0};
        vecs[5]  = '{3'd4, 3'd7, 0, 2'b00, 6'd28, 1'b0};
        vecs[6]  = '{3'd1, 3'd1, 2, 2'b00, 6'd1,  1'b0};
        vecs[7]  = '{3'd3, 3'd5, 0, 2'b10, 6'd15, 1'b1};
        vecs[8]  = '{3'd2, 3'd2, 0, 2'b00, 6'd4,  1'b1};
        vecs[9]  = '{3'd6, 3'd5, 3, 2'b00, 6'd30, 1'b1};
        vecs[10] = '{3'd0, 3'd7, 0, 2'b00, 6'd0,  1'b1};

`ifdef AXI_LUT_FILL_EN
        aw_delay = 2;
`endif
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;

`ifdef AXI_LUT_FILL_EN
        wait_not_busy(3000, "fill_done");
        check("fill_writes_at_busy_fall", 32'(wr_count), 32'd64);
        check("fill_entry_fc", mem[63], 32'd49);
        n   = 0;
        dup = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== 32'((i >> 3) * (i & 7))) n++;
            if (hits[i] != 1) dup++;
        end
        check("fill_content_bad", 32'(n), 32'd0);
        check("fill_write_count_per_entry", 32'(dup), 32'd0);
        aw_delay = 0;
`endif

        for (int i = 0; i < 11; i++) begin
            do_lookup(vecs[i].a, vecs[i].b, vecs[i].ar_delay, vecs[i].rresp, res, lat, pulses, addr_seen);
            check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].exp_result));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(3 + vecs[i].ar_delay));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
            check($sformatf("v%0d_resp_err", i), 32'(resp_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_araddr", i), addr_seen,
                  BASE + 32'((int'(vecs[i].a) * 8 + int'(vecs[i].b)) * 4));
        end

        // read strobes during RD_AR and RD_R must be dropped
        ar_delay  = 3;
        rresp_cfg = 2'b00;
        hs_before = ar_hs_count;
        @(negedge clk);
        a    = 3'd1;
        b    = 3'd2;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        a    = 3'd3;
        b    = 3'd3;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        n    = 0;
        while (dbg_state != ST_RD_R && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_seq_reach_rd_r", 32'(dbg_state), 32'(ST_RD_R));
        a      = 3'd4;
        b      = 3'd4;
        read   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            read = 1'b0;
            pulses += int'(result_valid);
        end
        check("busy_seq_pulses", 32'(pulses), 32'd1);
        check("busy_seq_result", 32'(result), 32'd2);
        check("busy_seq_ar_count", 32'(ar_hs_count - hs_before), 32'd1);
        check("busy_seq_idle", 32'(dbg_state), 32'(ST_IDLE));

        // reset in the middle of a lookup (resp_err is set at this point)
        ar_delay = 3;
        @(negedge clk);
        a    = 3'd5;
        b    = 3'd6;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("mid_lookup_reset");
        ar_delay = 0;
        @(negedge clk);
        rst = 1'b1;

`ifdef AXI_LUT_FILL_EN
        n = 0;
        while (wr_count < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("refill_reached_idx20", 32'(wr_count), 32'd20);
        rst = 1'b0;
        #1;
        check_reset_values("mid_fill_reset");
        @(negedge clk);
        rst = 1'b1;
        n   = 0;
        while (!first_seen && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("refill_first_awaddr", first_wr_addr, BASE);
        wait_not_busy(3000, "refill_done");
        check("refill_writes", 32'(wr_count), 32'd64);
        n = 0;
        for (int i = 0; i < N; i++) if (hits[i] != 1) n++;
        check("refill_write_count_per_entry", 32'(n), 32'd0);
`endif

        do_lookup(3'd7, 3'd6, 0, 2'b00, res, lat, pulses, addr_seen);
        check("post_reset_result", 32'(res), 32'd42);
        check("post_reset_latency", 32'(lat), 32'd3);
        check("post_reset_resp_err", 32'(resp_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
